// File: rtl/bht_update_ctrl_pkg.sv
// Shared types, table geometry and 2-bit saturating-counter helpers for the BHT
// update path; the counter helpers are also used by the predictor.
package bht_update_ctrl_pkg;

    localparam int BHT_SIZE       = 256;
    localparam int IDX_W          = 8;
    localparam int HISTORY_LENGTH = 2;
    localparam int FIFO_DEPTH     = 4;

    localparam logic [HISTORY_LENGTH-1:0] SN = 2'b00;
    localparam logic [HISTORY_LENGTH-1:0] WN = 2'b01;
    localparam logic [HISTORY_LENGTH-1:0] WT = 2'b10;
    localparam logic [HISTORY_LENGTH-1:0] ST = 2'b11;

    localparam logic [HISTORY_LENGTH-1:0] INIT_STATE = WN;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_entry_t;

    function automatic logic [HISTORY_LENGTH-1:0] sat_inc(input logic [HISTORY_LENGTH-1:0] c);
        return (c == ST) ? ST : c + HISTORY_LENGTH'(1);
    endfunction

    function automatic logic [HISTORY_LENGTH-1:0] sat_dec(input logic [HISTORY_LENGTH-1:0] c);
        return (c == SN) ? SN : c - HISTORY_LENGTH'(1);
    endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates awaiting their BHT write.
// A clear takes priority over any push or pop in the same cycle.
module bht_upd_fifo #(
    parameter int DW    = 9,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// Owner of the BHT write port: sweeps INIT_STATE into every entry after reset or
// flush, then retires queued branch resolutions as saturating-counter updates.
//
// state | meaning
// INIT  | sweep writing INIT_STATE to index sweep_idx; updates refused
// RUN   | accept updates into the FIFO, retire the head one per cycle
module bht_update_ctrl
    import bht_update_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_ni,
    input  logic                      flush_req_i,
    input  logic                      upd_valid_i,
    input  logic [31:0]               upd_pc_i,
    input  logic                      upd_taken_i,
    output logic                      upd_ready_o,
    output logic [IDX_W-1:0]          bht_rd_addr_o,
    input  logic [HISTORY_LENGTH-1:0] bht_rd_data_i,
    output logic                      bht_we_o,
    output logic [IDX_W-1:0]          bht_wr_addr_o,
    output logic [HISTORY_LENGTH-1:0] bht_wr_data_o,
    output logic                      busy_o,
    output logic [7:0]                drop_cnt_o
);

    bht_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    upd_entry_t fifo_wdata, fifo_rdata;
    logic       fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
    logic       ready;
    logic       unused_pc;

    assign unused_pc  = ^{upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};
    assign fifo_wdata = '{idx: upd_pc_i[IDX_W+1:2], taken: upd_taken_i};

    bht_upd_fifo #(
        .DW    ($bits(upd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bht_rd_addr_o = fifo_rdata.idx;
    assign drop_cnt_o    = drop_cnt_q;
    assign upd_ready_o   = ready;

    always_comb begin
        state_d       = state_q;
        sweep_idx_d   = sweep_idx_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_clear    = 1'b0;
        ready         = 1'b0;
        busy_o        = 1'b0;
        bht_we_o      = 1'b0;
        bht_wr_addr_o = fifo_rdata.idx;
        bht_wr_data_o = fifo_rdata.taken ? sat_inc(bht_rd_data_i) : sat_dec(bht_rd_data_i);

        case (state_q)
            INIT: begin
                busy_o        = 1'b1;
                bht_we_o      = 1'b1;
                bht_wr_addr_o = sweep_idx_q;
                bht_wr_data_o = INIT_STATE;
                if (flush_req_i) begin
                    sweep_idx_d = '0;
                end else if (sweep_idx_q == IDX_W'(BHT_SIZE - 1)) begin
                    sweep_idx_d = '0;
                    state_d     = RUN;
                end else begin
                    sweep_idx_d = sweep_idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                // ready comes from registered occupancy only, never from this cycle's pop
                ready    = !fifo_full;
                bht_we_o = !fifo_empty;
                fifo_pop = !fifo_empty;
                if (flush_req_i) begin
                    state_d     = INIT;
                    sweep_idx_d = '0;
                    fifo_clear  = 1'b1;
                end else begin
                    fifo_push = upd_valid_i && ready;
                end
            end
            default: begin
                state_d     = INIT;
                sweep_idx_d = '0;
            end
        endcase

        if (upd_valid_i && !ready && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            sweep_idx_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sweep_idx_q <= sweep_idx_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

endmodule
